// File: rtl/id_ex_stage.sv
// RV32I decode stage and ID/EX pipeline register.
// Handles load-use bubble insertion, EX backpressure and redirect flush.
module id_ex_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned BCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_ready,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    input  logic [XLEN-1:0]   rd1,
    input  logic [XLEN-1:0]   rd2,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [6:0]        ex_opcode,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              ex_we,
    output logic              ex_is_load,
    output logic              ex_is_store,
    output logic              ex_illegal,
    output logic [BCNT_W-1:0] bubble_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0]      dec_opcode;
    logic [4:0]      dec_rd;
    logic [XLEN-1:0] dec_imm;
    logic            dec_uses_rs1;
    logic            dec_uses_rs2;
    logic            dec_we;
    logic            dec_illegal;
    logic            hz;
    logic            advance;

    assign rs1        = if_instr[19:15];
    assign rs2        = if_instr[24:20];
    assign dec_opcode = if_instr[6:0];
    assign dec_rd     = if_instr[11:7];

    // Immediate generation and control decode
    always_comb begin
        dec_imm      = '0;
        dec_uses_rs1 = 1'b1;
        dec_uses_rs2 = 1'b0;
        dec_we       = 1'b0;
        dec_illegal  = 1'b0;
        case (dec_opcode)
            OP_LOAD, OP_IMM, OP_JALR: begin
                dec_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
                dec_we  = 1'b1;
            end
            OP_STORE: begin
                dec_imm      = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                dec_uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                dec_imm      = {{(XLEN-12){if_instr[31]}}, if_instr[7], if_instr[30:25],
                                if_instr[11:8], 1'b0};
                dec_uses_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec_imm      = {if_instr[31:12], 12'b0};
                dec_uses_rs1 = 1'b0;
                dec_we       = 1'b1;
            end
            OP_JAL: begin
                dec_imm      = {{(XLEN-20){if_instr[31]}}, if_instr[19:12], if_instr[20],
                                if_instr[30:21], 1'b0};
                dec_uses_rs1 = 1'b0;
                dec_we       = 1'b1;
            end
            OP_OP: begin
                dec_uses_rs2 = 1'b1;
                dec_we       = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: ;
            default: dec_illegal = 1'b1;
        endcase
        if (if_instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end
        if (dec_illegal || dec_rd == 5'd0) begin
            dec_we = 1'b0;
        end
    end

    // A load in EX whose rd feeds the instruction in ID costs one bubble
    assign hz = if_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                ((dec_uses_rs1 && rs1 == ex_rd) || (dec_uses_rs2 && rs2 == ex_rd));

    assign advance  = !ex_valid || ex_ready;
    assign if_ready = flush || (advance && !hz);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7   <= '0;
            ex_we       <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_is_store <= 1'b0;
            ex_illegal  <= 1'b0;
            bubble_cnt  <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (advance && hz) begin
            ex_valid <= 1'b0;
            if (bubble_cnt != {BCNT_W{1'b1}}) begin
                bubble_cnt <= bubble_cnt + BCNT_W'(1);
            end
        end else if (advance) begin
            ex_valid    <= if_valid;
            ex_pc       <= if_pc;
            ex_rs1_val  <= rd1;
            ex_rs2_val  <= rd2;
            ex_imm      <= dec_imm;
            ex_rs1      <= rs1;
            ex_rs2      <= rs2;
            ex_rd       <= dec_rd;
            ex_opcode   <= dec_opcode;
            ex_funct3   <= if_instr[14:12];
            ex_funct7   <= if_instr[31:25];
            ex_we       <= if_valid && dec_we;
            ex_is_load  <= if_valid && !dec_illegal && (dec_opcode == OP_LOAD);
            ex_is_store <= if_valid && !dec_illegal && (dec_opcode == OP_STORE);
            ex_illegal  <= if_valid && dec_illegal;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboarded bench for id_ex_stage: directed RV32I vectors, hazards, backpressure, flush.
// A second instance with a 2-bit bubble counter exercises saturation.
module tb_id_ex_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        we;
        logic        ld;
        logic        st;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [4:0]  rs1, rs2;
    logic [31:0] rd1, rd2;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [6:0]  ex_opcode, ex_funct7;
    logic [2:0]  ex_funct3;
    logic        ex_we, ex_is_load, ex_is_store, ex_illegal;
    logic [15:0] bubble_cnt;

    logic        s_if_ready, s_ex_valid;
    logic [4:0]  s_rs1, s_rs2, s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic [31:0] s_ex_pc, s_ex_rs1_val, s_ex_rs2_val, s_ex_imm;
    logic [6:0]  s_ex_opcode, s_ex_funct7;
    logic [2:0]  s_ex_funct3;
    logic        s_ex_we, s_ex_is_load, s_ex_is_store, s_ex_illegal;
    logic [1:0]  s_bubble_cnt;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   st;

    always #5 clk = ~clk;

    // Register file model: value encodes the index read
    assign rd1 = 32'hA000_0000 | 32'(rs1);
    assign rd2 = 32'hB000_0000 | 32'(rs2);

    id_ex_stage #(.XLEN(32), .BCNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(if_ready), .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2), .flush(flush),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
        .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_illegal(ex_illegal), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.XLEN(32), .BCNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(s_if_ready), .rs1(s_rs1), .rs2(s_rs2), .rd1(rd1), .rd2(rd2), .flush(flush),
        .ex_ready(ex_ready), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rs1_val(s_ex_rs1_val),
        .ex_rs2_val(s_ex_rs2_val), .ex_imm(s_ex_imm), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2),
        .ex_rd(s_ex_rd), .ex_opcode(s_ex_opcode), .ex_funct3(s_ex_funct3),
        .ex_funct7(s_ex_funct7), .ex_we(s_ex_we), .ex_is_load(s_ex_is_load),
        .ex_is_store(s_ex_is_store), .ex_illegal(s_ex_illegal), .bubble_cnt(s_bubble_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present an instruction until accepted; queue its expected EX image
    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic we, input logic ld, input logic sto, input logic ill,
                        output int stalls);
        exp_t e;
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        stalls   = 0;
        forever begin
            @(negedge clk);
            if (if_ready || stalls > 20) break;
            stalls++;
        end
        if (if_ready) begin
            e.pc = pc; e.rs1v = 32'hA000_0000 | 32'(r1); e.rs2v = 32'hB000_0000 | 32'(r2);
            e.imm = imm; e.rd = rd; e.r1 = r1; e.r2 = r2;
            e.we = we; e.ld = ld; e.st = sto; e.ill = ill;
            q.push_back(e);
        end else begin
            chk("send_timeout", 32'(stalls), 32'd0);
        end
        @(posedge clk);
        #1;
        if_valid = 1'b0;
    endtask

    // Monitor: every instruction leaving EX is checked against the queue head
    always @(negedge clk) begin
        if (rst_n && ex_valid && ex_ready) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 32'(ex_pc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_pc", ex_pc, e.pc);
                chk("sb_rs1_val", ex_rs1_val, e.rs1v);
                chk("sb_rs2_val", ex_rs2_val, e.rs2v);
                chk("sb_imm", ex_imm, e.imm);
                chk("sb_rd", 32'(ex_rd), 32'(e.rd));
                chk("sb_rs1", 32'(ex_rs1), 32'(e.r1));
                chk("sb_rs2", 32'(ex_rs2), 32'(e.r2));
                chk("sb_flags", {28'd0, ex_we, ex_is_load, ex_is_store, ex_illegal},
                    {28'd0, e.we, e.ld, e.st, e.ill});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; ex_ready = 1'b1;
        #2;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd1);
        chk("rst_bubble", 32'(bubble_cnt), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset asserted while EX holds a valid instruction
        send(32'h00500093, 32'h100, 32'd5, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, st);
        chk("pre_rst_valid", 32'(ex_valid), 32'd1);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_valid", 32'(ex_valid), 32'd0);
        chk("mid_rst_pc", ex_pc, 32'd0);
        chk("mid_rst_imm", ex_imm, 32'd0);
        chk("mid_rst_rd", 32'(ex_rd), 32'd0);
        chk("mid_rst_we", 32'(ex_we), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        send(32'h00500093, 32'h104, 32'd5, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, st);
        send(32'hFE20AE23, 32'h108, 32'hFFFF_FFFC, 5'd28, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, st);
        send(32'h001000EF, 32'h10C, 32'h0000_0800, 5'd1, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, st);
        send(32'hFFFFFFFF, 32'h110, 32'd0, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1, st);

        // lw x5,0(x1) ; add x6,x5,x0
        send(32'h0000A283, 32'h114, 32'd0, 5'd5, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, st);
        send(32'h00028333, 32'h118, 32'd0, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, st);
        chk("lu_stalls", 32'(st), 32'd1);
        chk("lu_bubble", 32'(bubble_cnt), 32'd1);
        chk("lu_bubble_sat", 32'(s_bubble_cnt), 32'd1);

        // lw x0,0(x1) ; add x6,x0,x0
        send(32'h0000A003, 32'h11C, 32'd0, 5'd0, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, st);
        send(32'h00000333, 32'h120, 32'd0, 5'd6, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, st);
        chk("x0_stalls", 32'(st), 32'd0);
        chk("x0_bubble", 32'(bubble_cnt), 32'd1);

        // Backpressure for three cycles behind addi x2,x0,7
        send(32'h00700113, 32'h124, 32'd7, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, st);
        ex_ready = 1'b0;
        fork
            send(32'h00900193, 32'h128, 32'd9, 5'd3, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, st);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("bp_valid", 32'(ex_valid), 32'd1);
                    chk("bp_rd", 32'(ex_rd), 32'd2);
                    chk("bp_imm", ex_imm, 32'd7);
                    chk("bp_if_ready", 32'(if_ready), 32'd0);
                end
                @(posedge clk); #1 ex_ready = 1'b1;
            end
        join
        chk("bp_stalls", 32'(st), 32'd3);

        // Flush on top of a load-use hazard
        send(32'h0000A283, 32'h12C, 32'd0, 5'd5, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, st);
        if_valid = 1'b1; if_instr = 32'h00028333; if_pc = 32'h130; flush = 1'b1;
        @(negedge clk);
        chk("fl_if_ready", 32'(if_ready), 32'd1);
        @(posedge clk); #1 flush = 1'b0; if_valid = 1'b0;
        @(negedge clk);
        chk("fl_ex_valid", 32'(ex_valid), 32'd0);
        chk("fl_bubble", 32'(bubble_cnt), 32'd1);
        @(negedge clk);
        chk("idle_valid", 32'(ex_valid), 32'd0);
        chk("idle_we_gated", 32'(ex_we), 32'd0);
        @(posedge clk); #1;

        // Four more load-use pairs: five bubbles in total
        for (int k = 2; k <= 5; k++) begin
            send(32'h0000A283, 32'h200 + 32'(8 * k), 32'd0, 5'd5, 5'd1, 5'd0,
                 1'b1, 1'b1, 1'b0, 1'b0, st);
            send(32'h00028333, 32'h204 + 32'(8 * k), 32'd0, 5'd6, 5'd5, 5'd0,
                 1'b1, 1'b0, 1'b0, 1'b0, st);
            chk("sat_stalls", 32'(st), 32'd1);
            chk("sat_bubble16", 32'(bubble_cnt), 32'(k));
            chk("sat_bubble2", 32'(s_bubble_cnt), (k > 3) ? 32'd3 : 32'(k));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register of the 5-stage RV32I pipeline.
- Slices rs1/rs2 from the fetched instruction and drives them combinationally to the register file. Same cycle, it samples rd1/rd2 (write-through already applied), generates the immediate, and registers operands and control into EX.
- Detects load-use hazards, inserts bubbles and counts them.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- BCNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch presents a valid instruction.
- if_instr  in  32  instruction word.
- if_pc  in  32  PC of if_instr.
- if_ready  out  1  ID accepts the instruction this cycle (combinational).
- rs1  out  5  = if_instr[19:15], to the register file.
- rs2  out  5  = if_instr[24:20], to the register file.
- rd1  in  32  register-file read data 1.
- rd2  in  32  register-file read data 2.
- flush  in  1  EX redirect (taken branch/jump); kills ID and EX contents.
- ex_ready  in  1  EX can accept/advance.
- ex_valid  out  1  EX holds a valid instruction.
- ex_pc  out  32  registered PC.
- ex_rs1_val  out  32  registered rd1.
- ex_rs2_val  out  32  registered rd2.
- ex_imm  out  32  sign-extended immediate.
- ex_rs1  out  5  registered rs1 index, for forwarding.
- ex_rs2  out  5  registered rs2 index, for forwarding.
- ex_rd  out  5  registered rd index.
- ex_opcode  out  7  registered opcode.
- ex_funct3  out  3  registered funct3.
- ex_funct7  out  7  registered funct7.
- ex_we  out  1  instruction writes rd (forced 0 when rd==0).
- ex_is_load  out  1  LOAD opcode.
- ex_is_store  out  1  STORE opcode.
- ex_illegal  out  1  opcode outside the RV32I base set.
- bubble_cnt  out  BCNT_W  number of load-use bubbles inserted.

Behaviour:
- Reset, asynchronous on rst_n low:
  - All ex_* outputs clear to 0 and bubble_cnt clears to 0.
  - if_ready is still driven combinationally; with ex_valid=0 it evaluates to 1.
  - Reset mid-stall drops the stalled instruction.
- Decode is combinational from if_instr.
  - Immediate formats:
    - I (LOAD, OP-IMM, JALR): sext(instr[31:20]).
    - S: sext({[31:25],[11:7]}).
    - B: sext({[31],[7],[30:25],[11:8],1'b0}).
    - U (LUI, AUIPC): {[31:12],12'b0}.
    - J: sext({[31],[19:12],[20],[30:21],1'b0}).
    - Otherwise 0.
  - uses_rs1 = opcode not in {LUI, AUIPC, JAL}.
  - uses_rs2 = opcode in {OP, STORE, BRANCH}.
  - ex_we source = opcode in {OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC} and rd != 0.
  - ex_illegal source = opcode not in the RV32I base set, or instr[1:0] != 2'b11. Such instructions still flow with ex_we=0.
- Load-use hazard:
  - hz = if_valid & ex_valid & ex_is_load & ex_rd != 0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- advance = ~ex_valid | ex_ready.
- if_ready = flush | (advance & ~hz).
- Per-edge update, in priority order:
  1. flush: ex_valid<=0. The ID instruction is consumed and discarded. No bubble count.
  2. advance & hz: ex_valid<=0 (bubble); if_ready=0 so fetch holds. bubble_cnt++, saturating at all-ones.
  3. advance & ~hz: load all ex_* from decode. ex_valid<=if_valid. Control flags are gated: ex_we, ex_is_load, ex_is_store and ex_illegal are 0 when if_valid=0.
  4. ~advance: hold all ex_* registers; if_ready=0.
- Latency: one cycle from acceptance to ex_valid.
- A load-use pair costs exactly one bubble. After the bubble the load has left EX, so hz deasserts and the consumer is accepted.
- Operands are not re-read while held. EX/MEM forwarding owns correctness after the bubble.
- rs1/rs2 are driven even when if_valid=0; this is harmless.

Test Plan:
- Reset: rst_n=0 mid-stream with ex_valid=1 -> all ex_* are 0 immediately. After release, first if_valid with addi x1,x0,5 (0x00500093) -> next cycle ex_valid=1, ex_imm=5, ex_rd=1, ex_we=1.
- Immediates:
  - sw x2,-4(x1) (0xFE20AE23) -> ex_imm=0xFFFFFFFC, ex_is_store=1, ex_we=0.
  - jal x1,+2048 (0x001000EF) -> ex_imm=0x00000800.
- Load-use:
  - lw x5,0(x1) then add x6,x5,x0 with ex_ready=1 -> one cycle with if_ready=0 and a bubble (ex_valid=0); bubble_cnt=1; add enters EX the following cycle.
  - Same pair with rd=x0 -> no bubble.
- Backpressure: ex_ready=0 for 3 cycles with valid EX contents -> ex_* unchanged and if_ready=0. The cycle ex_ready=1 -> next instruction loads.
- Flush: flush=1 while hz=1 -> if_ready=1, ex_valid=0 next cycle, bubble_cnt unchanged.
- Saturation: with BCNT_W=2, force 5 load-use pairs -> bubble_cnt stops at 3.
